// File: rtl/fetch_inst_queue_pkg.sv
// Shared fetch-side widths and the instruction-queue entry layout.
package fetch_inst_queue_pkg;

    localparam int unsigned INST_WIDTH      = 32;
    localparam int unsigned INST_ADDR_WIDTH = 32;
    localparam int unsigned BP_GHR_BITS     = 8;
    localparam int unsigned IF_BATCH_SIZE   = 2;

    localparam int unsigned FIQ_ENTRY_W = INST_WIDTH + 2 * INST_ADDR_WIDTH + 1 + BP_GHR_BITS;
    localparam int unsigned FIQ_DEPTH   = 8;

    typedef struct packed {
        logic [INST_WIDTH-1:0]      inst;
        logic [INST_ADDR_WIDTH-1:0] pc;
        logic                       pred_taken;
        logic [INST_ADDR_WIDTH-1:0] pred_target;
        logic [BP_GHR_BITS-1:0]     pred_hist;
    } fiq_entry_t;

endpackage

// File: rtl/fetch_inst_queue.sv
// 2-wide circular instruction queue between fetch/branch-predict and pre-decode.
// Head batch is presented combinationally; flush empties the queue in one cycle.
module fetch_inst_queue
    import fetch_inst_queue_pkg::*;
#(
    parameter  int unsigned DEPTH = FIQ_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,

    input  logic [IF_BATCH_SIZE-1:0]   in_inst_valid,
    input  logic [INST_WIDTH-1:0]      in_inst_0,
    input  logic [INST_WIDTH-1:0]      in_inst_1,
    input  logic [INST_ADDR_WIDTH-1:0] in_pc_0,
    input  logic [INST_ADDR_WIDTH-1:0] in_pc_1,
    input  logic                       in_pred_taken_0,
    input  logic                       in_pred_taken_1,
    input  logic [INST_ADDR_WIDTH-1:0] in_pred_target_0,
    input  logic [INST_ADDR_WIDTH-1:0] in_pred_target_1,
    input  logic [BP_GHR_BITS-1:0]     in_pred_hist_0,
    input  logic [BP_GHR_BITS-1:0]     in_pred_hist_1,
    output logic                       in_ready,

    output logic [IF_BATCH_SIZE-1:0]   out_inst_valid,
    output logic [INST_WIDTH-1:0]      out_inst_0,
    output logic [INST_WIDTH-1:0]      out_inst_1,
    output logic [INST_ADDR_WIDTH-1:0] out_pc_0,
    output logic [INST_ADDR_WIDTH-1:0] out_pc_1,
    output logic                       out_pred_taken_0,
    output logic                       out_pred_taken_1,
    output logic [INST_ADDR_WIDTH-1:0] out_pred_target_0,
    output logic [INST_ADDR_WIDTH-1:0] out_pred_target_1,
    output logic [BP_GHR_BITS-1:0]     out_pred_hist_0,
    output logic [BP_GHR_BITS-1:0]     out_pred_hist_1,
    input  logic                       out_ready,

    output logic [PTR_W:0]             count
);

    localparam int unsigned CNT_W = PTR_W + 1;

    function automatic logic [1:0] popcnt2(input logic [1:0] v);
        return 2'({1'b0, v[0]} + {1'b0, v[1]});
    endfunction

    fiq_entry_t mem_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    fiq_entry_t       lane0_in, lane1_in;
    fiq_entry_t       rd0, rd1;
    fiq_entry_t       wr0_data, wr1_data;
    logic             wr0_en, wr1_en;
    logic [PTR_W-1:0] wr0_idx, wr1_idx;
    logic             enq_fire;
    logic [1:0]       n_enq, n_deq;
    logic             out_v0, out_v1;

    assign lane0_in = '{inst: in_inst_0, pc: in_pc_0, pred_taken: in_pred_taken_0,
                        pred_target: in_pred_target_0, pred_hist: in_pred_hist_0};
    assign lane1_in = '{inst: in_inst_1, pc: in_pc_1, pred_taken: in_pred_taken_1,
                        pred_target: in_pred_target_1, pred_hist: in_pred_hist_1};

    // Two free slots are required so a full batch never overwrites the head being read.
    assign in_ready = (count_q <= CNT_W'(DEPTH - 2));
    assign enq_fire = in_ready && (|in_inst_valid) && !flush;
    assign n_enq    = enq_fire ? popcnt2(in_inst_valid) : 2'd0;

    assign out_v0 = (count_q != '0);
    assign out_v1 = (count_q >= CNT_W'(2));
    assign n_deq  = out_ready ? popcnt2({out_v1, out_v0}) : 2'd0;

    // Compact sparse lanes so the first valid lane always lands at tail.
    always_comb begin
        wr0_en   = 1'b0;
        wr1_en   = 1'b0;
        wr0_idx  = tail_q;
        wr1_idx  = PTR_W'(tail_q + PTR_W'(1));
        wr0_data = lane0_in;
        wr1_data = lane1_in;
        if (enq_fire) begin
            if (in_inst_valid[0]) begin
                wr0_en = 1'b1;
                wr1_en = in_inst_valid[1];
            end else begin
                wr0_en   = 1'b1;
                wr0_data = lane1_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr0_en) mem_q[wr0_idx] <= wr0_data;
        if (wr1_en) mem_q[wr1_idx] <= wr1_data;
    end

    always_comb begin
        head_d  = PTR_W'(head_q + PTR_W'(n_deq));
        tail_d  = PTR_W'(tail_q + PTR_W'(n_enq));
        count_d = CNT_W'(count_q + CNT_W'(n_enq) - CNT_W'(n_deq));
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Invalid lanes are zeroed field-for-field so pre-decode never sees stale payload.
    assign rd0 = out_v0 ? mem_q[head_q] : '0;
    assign rd1 = out_v1 ? mem_q[PTR_W'(head_q + PTR_W'(1))] : '0;

    assign out_inst_valid    = {out_v1, out_v0};
    assign out_inst_0        = rd0.inst;
    assign out_inst_1        = rd1.inst;
    assign out_pc_0          = rd0.pc;
    assign out_pc_1          = rd1.pc;
    assign out_pred_taken_0  = rd0.pred_taken;
    assign out_pred_taken_1  = rd1.pred_taken;
    assign out_pred_target_0 = rd0.pred_target;
    assign out_pred_target_1 = rd1.pred_target;
    assign out_pred_hist_0   = rd0.pred_hist;
    assign out_pred_hist_1   = rd1.pred_hist;
    assign count             = count_q;

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Scoreboard bench for fetch_inst_queue: stimulus posts fetch batches, a negedge
// monitor keeps the expected FIFO contents and compares the presented head batch.
module tb_fetch_inst_queue;
    import fetch_inst_queue_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [INST_WIDTH-1:0]      inst;
        logic [INST_ADDR_WIDTH-1:0] pc;
        logic                       tk;
        logic [INST_ADDR_WIDTH-1:0] tgt;
        logic [BP_GHR_BITS-1:0]     hist;
    } ent_t;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       flush = 1'b0;
    logic [1:0]                 in_inst_valid = '0;
    logic [INST_WIDTH-1:0]      in_inst_0 = '0, in_inst_1 = '0;
    logic [INST_ADDR_WIDTH-1:0] in_pc_0 = '0, in_pc_1 = '0;
    logic                       in_pred_taken_0 = 1'b0, in_pred_taken_1 = 1'b0;
    logic [INST_ADDR_WIDTH-1:0] in_pred_target_0 = '0, in_pred_target_1 = '0;
    logic [BP_GHR_BITS-1:0]     in_pred_hist_0 = '0, in_pred_hist_1 = '0;
    logic                       in_ready;
    logic [1:0]                 out_inst_valid;
    logic [INST_WIDTH-1:0]      out_inst_0, out_inst_1;
    logic [INST_ADDR_WIDTH-1:0] out_pc_0, out_pc_1;
    logic                       out_pred_taken_0, out_pred_taken_1;
    logic [INST_ADDR_WIDTH-1:0] out_pred_target_0, out_pred_target_1;
    logic [BP_GHR_BITS-1:0]     out_pred_hist_0, out_pred_hist_1;
    logic                       out_ready = 1'b0;
    logic [PTR_W:0]             count;

    fetch_inst_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_inst_valid(in_inst_valid),
        .in_inst_0(in_inst_0), .in_inst_1(in_inst_1),
        .in_pc_0(in_pc_0), .in_pc_1(in_pc_1),
        .in_pred_taken_0(in_pred_taken_0), .in_pred_taken_1(in_pred_taken_1),
        .in_pred_target_0(in_pred_target_0), .in_pred_target_1(in_pred_target_1),
        .in_pred_hist_0(in_pred_hist_0), .in_pred_hist_1(in_pred_hist_1),
        .in_ready(in_ready),
        .out_inst_valid(out_inst_valid),
        .out_inst_0(out_inst_0), .out_inst_1(out_inst_1),
        .out_pc_0(out_pc_0), .out_pc_1(out_pc_1),
        .out_pred_taken_0(out_pred_taken_0), .out_pred_taken_1(out_pred_taken_1),
        .out_pred_target_0(out_pred_target_0), .out_pred_target_1(out_pred_target_1),
        .out_pred_hist_0(out_pred_hist_0), .out_pred_hist_1(out_pred_hist_1),
        .out_ready(out_ready),
        .count(count)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    ent_t exp_q[$];   // entries the queue should hold, oldest first
    ent_t pend_q[$];  // valid lanes of the batch currently on the inputs, in program order

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: compare presented outputs against the model, then advance the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_count", 128'(count), 128'(0));
            check("rst_in_ready", 128'(in_ready), 128'(1));
            check("rst_out_valid", 128'(out_inst_valid), 128'(0));
            check("rst_out_pc_0", 128'(out_pc_0), 128'(0));
            exp_q.delete();
        end else begin
            int   sz;
            logic rdy;
            ent_t e0, e1, a0, a1;
            sz  = exp_q.size();
            rdy = (int'(DEPTH) - sz) >= 2;
            e0  = (sz >= 1) ? exp_q[0] : '0;
            e1  = (sz >= 2) ? exp_q[1] : '0;
            a0  = '{inst: out_inst_0, pc: out_pc_0, tk: out_pred_taken_0,
                    tgt: out_pred_target_0, hist: out_pred_hist_0};
            a1  = '{inst: out_inst_1, pc: out_pc_1, tk: out_pred_taken_1,
                    tgt: out_pred_target_1, hist: out_pred_hist_1};
            check("count", 128'(count), 128'(sz));
            check("in_ready", 128'(in_ready), 128'(rdy));
            check("out_valid", 128'(out_inst_valid),
                  128'((sz >= 2) ? 2'b11 : (sz == 1) ? 2'b01 : 2'b00));
            check("lane0_entry", 128'(a0), 128'(e0));
            check("lane1_entry", 128'(a1), 128'(e1));
            if (flush) begin
                exp_q.delete();
            end else begin
                if (out_ready) begin
                    for (int i = 0; i < 2 && exp_q.size() > 0; i++) void'(exp_q.pop_front());
                end
                if (rdy) begin
                    foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
                end
            end
        end
    end

    function automatic ent_t rand_ent(input logic [31:0] pc);
        ent_t e;
        e.inst = INST_WIDTH'($urandom);
        e.pc   = INST_ADDR_WIDTH'(pc);
        e.tk   = 1'($urandom);
        e.tgt  = INST_ADDR_WIDTH'($urandom);
        e.hist = BP_GHR_BITS'($urandom);
        return e;
    endfunction

    // Apply one cycle of stimulus, post valid lanes to the scoreboard, wait one clock.
    task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                         input logic ordy, input logic fl);
        ent_t l0, l1;
        l0 = rand_ent(pc0);
        l1 = rand_ent(pc1);
        pend_q.delete();
        in_inst_valid    = v;
        in_inst_0        = l0.inst;  in_inst_1        = l1.inst;
        in_pc_0          = l0.pc;    in_pc_1          = l1.pc;
        in_pred_taken_0  = l0.tk;    in_pred_taken_1  = l1.tk;
        in_pred_target_0 = l0.tgt;   in_pred_target_1 = l1.tgt;
        in_pred_hist_0   = l0.hist;  in_pred_hist_1   = l1.hist;
        out_ready        = ordy;
        flush            = fl;
        if (v[0]) pend_q.push_back(l0);
        if (v[1]) pend_q.push_back(l1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        pend_q.delete();
        in_inst_valid = '0;
        out_ready     = 1'b0;
        flush         = 1'b0;
        rst_n         = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] pc;
        do_reset(2);

        // Reset then idle
        drive(2'b00, 0, 0, 1'b0, 1'b0);
        // Full batch, no drain
        drive(2'b11, 32'h100, 32'h104, 1'b0, 1'b0);
        drive(2'b00, 0, 0, 1'b0, 1'b0);
        drive(2'b00, 0, 0, 1'b1, 1'b0);
        drive(2'b00, 0, 0, 1'b0, 1'b0);
        // Sparse lane-1-only batch into empty queue
        drive(2'b10, 32'h204, 32'h208, 1'b0, 1'b0);
        drive(2'b00, 0, 0, 1'b0, 1'b0);
        drive(2'b00, 0, 0, 1'b1, 1'b0);

        // Fill to 7, a further single-lane batch must be ignored, then drain two
        drive(2'b11, 32'h300, 32'h304, 1'b0, 1'b0);
        drive(2'b11, 32'h308, 32'h30c, 1'b0, 1'b0);
        drive(2'b11, 32'h310, 32'h314, 1'b0, 1'b0);
        drive(2'b01, 32'h318, 32'h31c, 1'b0, 1'b0);
        drive(2'b01, 32'h320, 32'h324, 1'b0, 1'b0);
        drive(2'b00, 0, 0, 1'b0, 1'b0);
        drive(2'b00, 0, 0, 1'b1, 1'b0);
        drive(2'b00, 0, 0, 1'b0, 1'b0);
        repeat (3) drive(2'b00, 0, 0, 1'b1, 1'b0);

        // Steady stream across the pointer wrap
        pc = 32'h1000;
        for (int i = 0; i < 20; i++) begin
            drive(2'b11, pc, pc + 32'h4, 1'b1, 1'b0);
            pc += 32'h8;
        end
        drive(2'b00, 0, 0, 1'b1, 1'b0);
        drive(2'b00, 0, 0, 1'b0, 1'b0);

        // Flush at count=4 with a concurrent enqueue and dequeue
        drive(2'b11, 32'h500, 32'h504, 1'b0, 1'b0);
        drive(2'b11, 32'h508, 32'h50c, 1'b0, 1'b0);
        drive(2'b11, 32'h510, 32'h514, 1'b1, 1'b1);
        drive(2'b01, 32'h400, 32'h404, 1'b0, 1'b0);
        drive(2'b00, 0, 0, 1'b0, 1'b0);

        // Randomized traffic with rare flushes and one asynchronous mid-run reset
        for (int i = 0; i < 400; i++) begin
            logic [1:0] v;
            v  = 2'($urandom);
            pc = $urandom;
            if (i == 200) begin
                drive(2'b11, pc, pc + 32'h4, 1'b0, 1'b0);
                #2;
                do_reset(2);
            end
            drive(v, pc, pc + 32'h4, 1'($urandom_range(0, 2) != 0 ? ($urandom & 1) : 0),
                  1'($urandom_range(0, 31) == 0));
        end
        drive(2'b00, 0, 0, 1'b0, 1'b0);
        drive(2'b00, 0, 0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
